// File: rtl/pic_decode_seq_pkg.sv
// Shared encodings for the PIC16F decoder: ALU opcodes, PC/bit-unit ops, Q phases, control word.
// Latency: n/a (types and constants only); no backpressure.
package pic_decode_seq_pkg;

   typedef enum logic [3:0] {
      ALU_OP_ADD    = 4'd0,
      ALU_OP_SUB    = 4'd1,
      ALU_OP_AND    = 4'd2,
      ALU_OP_IOR    = 4'd3,
      ALU_OP_XOR    = 4'd4,
      ALU_OP_COM    = 4'd5,
      ALU_OP_DEC    = 4'd6,
      ALU_OP_INC    = 4'd7,
      ALU_OP_RLF    = 4'd8,
      ALU_OP_RRF    = 4'd9,
      ALU_OP_SWAP   = 4'd10,
      ALU_OP_PASSF  = 4'd11,
      ALU_OP_PASSW  = 4'd12,
      ALU_OP_PASSLF = 4'd13,
      ALU_OP_CLR    = 4'd14
   } alu_op_e;

   typedef enum logic [1:0] {PC_OP_INC = 2'd0, PC_OP_LOAD = 2'd1, PC_OP_POP = 2'd2} pc_op_e;
   typedef enum logic [1:0] {BIT_OP_NONE = 2'd0, BIT_OP_CLR = 2'd1, BIT_OP_SET = 2'd2, BIT_OP_TEST = 2'd3} bit_op_e;
   typedef enum logic [1:0] {Q1 = 2'd0, Q2 = 2'd1, Q3 = 2'd2, Q4 = 2'd3} q_phase_e;

   localparam logic [13:0] OPC_RETURN = 14'h0008;
   localparam logic [13:0] OPC_RETFIE = 14'h0009;
   localparam logic [13:0] OPC_SLEEP  = 14'h0063;
   localparam logic [13:0] OPC_CLRWDT = 14'h0064;

   // Unphased control word; the sequencer turns the flags into Q3/Q4 strobes.
   typedef struct packed {
      alu_op_e alu_op;
      logic    sel_lit;
      logic    status_en;
      logic    f_wr;
      logic    w_wr;
      bit_op_e bit_op;
      pc_op_e  pc_op;
      logic    push;
      logic    retfie;
      logic    illegal;
      logic    skip_z;
      logic    skip_bclr;
      logic    skip_bset;
      logic    redirect;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '{
      alu_op: ALU_OP_PASSF, sel_lit: 1'b0, status_en: 1'b0, f_wr: 1'b0, w_wr: 1'b0,
      bit_op: BIT_OP_NONE, pc_op: PC_OP_INC, push: 1'b0, retfie: 1'b0, illegal: 1'b0,
      skip_z: 1'b0, skip_bclr: 1'b0, skip_bset: 1'b0, redirect: 1'b0
   };

endpackage

// File: rtl/pic_decode_seq_if.sv
// Decoder <-> datapath bundle: fetched word and ALU flags in, phased control out.
// Latency: wires only; no backpressure.
interface pic_decode_seq_if #(
   parameter int F_ADDR_W = 7,
   parameter int PC_W     = 11
);
   logic [13:0]         instr_in;
   logic                alu_z_raw;
   logic                alu_bit_test_res;
   logic [1:0]          q_phase;
   logic [3:0]          alu_op;
   logic                alu_sel_lit;
   logic [7:0]          literal;
   logic                alu_status_wr_en;
   logic [F_ADDR_W-1:0] f_addr;
   logic                f_wr_en;
   logic                w_wr_en;
   logic [2:0]          bit_sel;
   logic [1:0]          bit_op;
   logic [1:0]          pc_op;
   logic                stack_push;
   logic [PC_W-1:0]     pc_lit;
   logic                retfie;
   logic                illegal;

   modport master (
      input  instr_in, alu_z_raw, alu_bit_test_res,
      output q_phase, alu_op, alu_sel_lit, literal, alu_status_wr_en, f_addr, f_wr_en,
             w_wr_en, bit_sel, bit_op, pc_op, stack_push, pc_lit, retfie, illegal
   );

   modport slave (
      output instr_in, alu_z_raw, alu_bit_test_res,
      input  q_phase, alu_op, alu_sel_lit, literal, alu_status_wr_en, f_addr, f_wr_en,
             w_wr_en, bit_sel, bit_op, pc_op, stack_push, pc_lit, retfie, illegal
   );
endinterface

// File: rtl/pic_op_decoder.sv
// Pure combinational PIC16F opcode decode: 14-bit IR to unphased control word.
// Latency: 0 cycles; no backpressure.
module pic_op_decoder
   import pic_decode_seq_pkg::*;
(
   input  logic [13:0] ir,
   output ctrl_t       ctrl
);

   always_comb begin
      ctrl = CTRL_NOP;
      casez (ir)
         14'b00_0000_1???????: begin
            ctrl.alu_op = ALU_OP_PASSW;
            ctrl.f_wr   = 1'b1;
         end
         14'b00_0000_0??0_0000, OPC_SLEEP, OPC_CLRWDT: begin
         end
         OPC_RETURN: begin
            ctrl.pc_op    = PC_OP_POP;
            ctrl.redirect = 1'b1;
         end
         OPC_RETFIE: begin
            ctrl.pc_op    = PC_OP_POP;
            ctrl.retfie   = 1'b1;
            ctrl.redirect = 1'b1;
         end
         14'b00_0000_0???????: ctrl.illegal = 1'b1;
         14'b00_0001_????????: begin
            ctrl.alu_op    = ALU_OP_CLR;
            ctrl.f_wr      = ir[7];
            ctrl.w_wr      = ~ir[7];
            ctrl.status_en = 1'b1;
         end
         14'b00_????_????????: begin
            // *WF byte ops: d selects f or W as destination
            ctrl.f_wr      = ir[7];
            ctrl.w_wr      = ~ir[7];
            ctrl.status_en = 1'b1;
            case (ir[11:8])
               4'b0010: ctrl.alu_op = ALU_OP_SUB;
               4'b0011: ctrl.alu_op = ALU_OP_DEC;
               4'b0100: ctrl.alu_op = ALU_OP_IOR;
               4'b0101: ctrl.alu_op = ALU_OP_AND;
               4'b0110: ctrl.alu_op = ALU_OP_XOR;
               4'b0111: ctrl.alu_op = ALU_OP_ADD;
               4'b1001: ctrl.alu_op = ALU_OP_COM;
               4'b1010: ctrl.alu_op = ALU_OP_INC;
               4'b1011: begin
                  ctrl.alu_op    = ALU_OP_DEC;
                  ctrl.status_en = 1'b0;
                  ctrl.skip_z    = 1'b1;
               end
               4'b1100: ctrl.alu_op = ALU_OP_RRF;
               4'b1101: ctrl.alu_op = ALU_OP_RLF;
               4'b1110: begin
                  ctrl.alu_op    = ALU_OP_SWAP;
                  ctrl.status_en = 1'b0;
               end
               4'b1111: begin
                  ctrl.alu_op    = ALU_OP_INC;
                  ctrl.status_en = 1'b0;
                  ctrl.skip_z    = 1'b1;
               end
               default: ctrl.alu_op = ALU_OP_PASSF;
            endcase
         end
         14'b01_????_????????: begin
            case (ir[11:10])
               2'b00: begin ctrl.bit_op = BIT_OP_CLR; ctrl.f_wr = 1'b1; end
               2'b01: begin ctrl.bit_op = BIT_OP_SET; ctrl.f_wr = 1'b1; end
               2'b10: begin ctrl.bit_op = BIT_OP_TEST; ctrl.skip_bclr = 1'b1; end
               default: begin ctrl.bit_op = BIT_OP_TEST; ctrl.skip_bset = 1'b1; end
            endcase
         end
         14'b10_0???_????????: begin
            ctrl.pc_op    = PC_OP_LOAD;
            ctrl.push     = 1'b1;
            ctrl.redirect = 1'b1;
         end
         14'b10_1???_????????: begin
            ctrl.pc_op    = PC_OP_LOAD;
            ctrl.redirect = 1'b1;
         end
         default: begin
            ctrl.sel_lit   = 1'b1;
            ctrl.w_wr      = 1'b1;
            ctrl.status_en = 1'b1;
            casez (ir[11:8])
               4'b00??: begin ctrl.alu_op = ALU_OP_PASSLF; ctrl.status_en = 1'b0; end
               4'b01??: begin
                  ctrl.alu_op    = ALU_OP_PASSLF;
                  ctrl.status_en = 1'b0;
                  ctrl.pc_op     = PC_OP_POP;
                  ctrl.redirect  = 1'b1;
               end
               4'b1000: ctrl.alu_op = ALU_OP_IOR;
               4'b1001: ctrl.alu_op = ALU_OP_AND;
               4'b1010: ctrl.alu_op = ALU_OP_XOR;
               4'b110?: ctrl.alu_op = ALU_OP_SUB;
               4'b111?: ctrl.alu_op = ALU_OP_ADD;
               default: begin
                  ctrl         = CTRL_NOP;
                  ctrl.illegal = 1'b1;
               end
            endcase
         end
      endcase
   end

endmodule

// File: rtl/pic_decode_seq.sv
// PIC16F Q-cycle sequencer: Q1-Q4 counter, IR fetch at Q4, flush of prefetched slot, phased strobes.
// Latency: word fetched in one 4-clock cycle executes in the next; no backpressure (free-running).
module pic_decode_seq
   import pic_decode_seq_pkg::*;
#(
   parameter int F_ADDR_W = 7,
   parameter int PC_W     = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   pic_decode_seq_if.master bus
);

   q_phase_e    q, q_nxt;
   logic [13:0] ir;
   logic        flush;
   ctrl_t       dec, c;
   logic        skip_taken;
   logic        at_q3, at_q4;

   pic_op_decoder u_dec (.ir(ir), .ctrl(dec));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= Q1;
      else        q <= q_nxt;
   end

   always_comb begin
      q_nxt = q;
      case (q)
         Q1: q_nxt = Q2;
         Q2: q_nxt = Q3;
         Q3: q_nxt = Q4;
         Q4: q_nxt = Q1;
         default: q_nxt = Q1;
      endcase
   end

   // A flushed slot decodes as NOP, so a skip sitting in it can never fire.
   always_comb begin
      c = flush ? CTRL_NOP : dec;
   end

   assign skip_taken = (c.skip_z & bus.alu_z_raw) |
                       (c.skip_bclr & ~bus.alu_bit_test_res) |
                       (c.skip_bset & bus.alu_bit_test_res);
   assign at_q3 = (q == Q3);
   assign at_q4 = (q == Q4);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir    <= 14'h0000;
         flush <= 1'b1;
      end else if (at_q4) begin
         ir    <= bus.instr_in;
         flush <= c.redirect | skip_taken;
      end
   end

   assign bus.q_phase          = q;
   assign bus.alu_op           = c.alu_op;
   assign bus.alu_sel_lit      = c.sel_lit;
   assign bus.literal          = ir[7:0];
   assign bus.alu_status_wr_en = c.status_en & at_q3;
   assign bus.f_addr           = ir[F_ADDR_W-1:0];
   assign bus.f_wr_en          = c.f_wr & at_q4;
   assign bus.w_wr_en          = c.w_wr & at_q4;
   assign bus.bit_sel          = ir[9:7];
   assign bus.bit_op           = c.bit_op;
   assign bus.pc_op            = c.pc_op;
   assign bus.stack_push       = c.push & at_q4;
   assign bus.pc_lit           = ir[PC_W-1:0];
   assign bus.retfie           = c.retfie & at_q4;
   assign bus.illegal          = c.illegal & at_q4;

endmodule

// File: tb/tb_pic_decode_seq.sv
// Directed table of instruction cycles for pic_decode_seq plus a mid-cycle reset sequence.
module tb_pic_decode_seq;
   import pic_decode_seq_pkg::*;

   typedef struct {
      logic [13:0] instr;   // word presented for fetch during this cycle
      logic        z;
      logic        b;
      logic [3:0]  op;      // expectations for the word executing this cycle
      logic        sl;
      logic [1:0]  bop;
      logic [1:0]  pcop;
      logic [5:0]  strb;    // {status@Q3, f_wr, w_wr, push, retfie, illegal @Q4}
      logic        chk_f;
      logic [7:0]  lit;
      logic [6:0]  fa;
      logic [10:0] pcl;
      logic [2:0]  bs;
   } vec_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   pic_decode_seq_if #(.F_ADDR_W(7), .PC_W(11)) bus ();

   pic_decode_seq #(.F_ADDR_W(7), .PC_W(11)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mkv(input logic [13:0] instr, input logic z, input logic b,
                                input logic [3:0] op, input logic sl, input logic [1:0] bop,
                                input logic [1:0] pcop, input logic [5:0] strb, input logic chk_f,
                                input logic [7:0] lit, input logic [6:0] fa, input logic [10:0] pcl,
                                input logic [2:0] bs);
      vec_t r;
      r.instr = instr; r.z = z; r.b = b; r.op = op; r.sl = sl; r.bop = bop; r.pcop = pcop;
      r.strb = strb; r.chk_f = chk_f; r.lit = lit; r.fa = fa; r.pcl = pcl; r.bs = bs;
      return r;
   endfunction

   function automatic vec_t nopv(input logic [13:0] instr, input logic z, input logic b);
      return mkv(instr, z, b, ALU_OP_PASSF, 1'b0, BIT_OP_NONE, PC_OP_INC, 6'b0, 1'b0,
                 8'h0, 7'h0, 11'h0, 3'h0);
   endfunction

   // Starts in Q1 just after the cycle's first edge; ends #1 after the next Q4->Q1 edge.
   task automatic run_row(input vec_t v, input int idx);
      logic [3:0] st, fw, ww, pu, rf, il;
      st = '0; fw = '0; ww = '0; pu = '0; rf = '0; il = '0;
      bus.instr_in         = v.instr;
      bus.alu_z_raw        = v.z;
      bus.alu_bit_test_res = v.b;
      for (int p = 0; p < 4; p++) begin
         @(negedge clk);
         chk($sformatf("r%0d q_phase", idx), 32'(bus.q_phase), 32'(p));
         st[p] = bus.alu_status_wr_en; fw[p] = bus.f_wr_en; ww[p] = bus.w_wr_en;
         pu[p] = bus.stack_push;       rf[p] = bus.retfie;  il[p] = bus.illegal;
         if (p == 1) begin
            chk($sformatf("r%0d alu_op", idx), 32'(bus.alu_op), 32'(v.op));
            chk($sformatf("r%0d alu_sel_lit", idx), 32'(bus.alu_sel_lit), 32'(v.sl));
            chk($sformatf("r%0d bit_op", idx), 32'(bus.bit_op), 32'(v.bop));
            if (v.chk_f) begin
               chk($sformatf("r%0d literal", idx), 32'(bus.literal), 32'(v.lit));
               chk($sformatf("r%0d f_addr", idx), 32'(bus.f_addr), 32'(v.fa));
               chk($sformatf("r%0d pc_lit", idx), 32'(bus.pc_lit), 32'(v.pcl));
               chk($sformatf("r%0d bit_sel", idx), 32'(bus.bit_sel), 32'(v.bs));
            end
         end
         if (p == 0 || p == 3)
            chk($sformatf("r%0d pc_op q%0d", idx, p + 1), 32'(bus.pc_op), 32'(v.pcop));
      end
      chk($sformatf("r%0d status_wr phases", idx), 32'(st), v.strb[5] ? 32'h4 : 32'h0);
      chk($sformatf("r%0d f_wr phases", idx), 32'(fw), v.strb[4] ? 32'h8 : 32'h0);
      chk($sformatf("r%0d w_wr phases", idx), 32'(ww), v.strb[3] ? 32'h8 : 32'h0);
      chk($sformatf("r%0d push phases", idx), 32'(pu), v.strb[2] ? 32'h8 : 32'h0);
      chk($sformatf("r%0d retfie phases", idx), 32'(rf), v.strb[1] ? 32'h8 : 32'h0);
      chk($sformatf("r%0d illegal phases", idx), 32'(il), v.strb[0] ? 32'h8 : 32'h0);
      @(posedge clk);
      #1;
   endtask

   vec_t tbl[23];

   initial begin
      logic any_strobe;
      checks = 0;
      errors = 0;

      tbl[0]  = nopv(14'h07A0, 1'b0, 1'b0);
      tbl[1]  = mkv(14'h3055, 0, 0, ALU_OP_ADD,    0, BIT_OP_NONE, PC_OP_INC,  6'b110000, 1, 8'hA0, 7'h20, 11'h7A0, 3'd7);
      tbl[2]  = mkv(14'h2923, 0, 0, ALU_OP_PASSLF, 1, BIT_OP_NONE, PC_OP_INC,  6'b001000, 1, 8'h55, 7'h55, 11'h055, 3'd0);
      tbl[3]  = mkv(14'h3E01, 0, 0, ALU_OP_PASSF,  0, BIT_OP_NONE, PC_OP_LOAD, 6'b000000, 1, 8'h23, 7'h23, 11'h123, 3'd2);
      tbl[4]  = nopv(14'h0BB0, 1'b0, 1'b0);
      tbl[5]  = mkv(14'h3011, 1, 0, ALU_OP_DEC,    0, BIT_OP_NONE, PC_OP_INC,  6'b010000, 1, 8'hB0, 7'h30, 11'h3B0, 3'd7);
      tbl[6]  = nopv(14'h0BB0, 1'b0, 1'b0);
      tbl[7]  = mkv(14'h3022, 0, 0, ALU_OP_DEC,    0, BIT_OP_NONE, PC_OP_INC,  6'b010000, 1, 8'hB0, 7'h30, 11'h3B0, 3'd7);
      tbl[8]  = mkv(14'h1D03, 0, 0, ALU_OP_PASSLF, 1, BIT_OP_NONE, PC_OP_INC,  6'b001000, 1, 8'h22, 7'h22, 11'h022, 3'd0);
      tbl[9]  = mkv(14'h2010, 0, 1, ALU_OP_PASSF,  0, BIT_OP_TEST, PC_OP_INC,  6'b000000, 1, 8'h03, 7'h03, 11'h503, 3'd2);
      tbl[10] = nopv(14'h2010, 1'b0, 1'b0);
      tbl[11] = mkv(14'h34AA, 0, 0, ALU_OP_PASSF,  0, BIT_OP_NONE, PC_OP_LOAD, 6'b000100, 1, 8'h10, 7'h10, 11'h010, 3'd0);
      tbl[12] = nopv(14'h34AA, 1'b0, 1'b0);
      tbl[13] = mkv(14'h0002, 0, 0, ALU_OP_PASSLF, 1, BIT_OP_NONE, PC_OP_POP,  6'b001000, 1, 8'hAA, 7'h2A, 11'h4AA, 3'd1);
      tbl[14] = nopv(14'h0002, 1'b0, 1'b0);
      tbl[15] = mkv(14'h1903, 0, 0, ALU_OP_PASSF,  0, BIT_OP_NONE, PC_OP_INC,  6'b000001, 1, 8'h02, 7'h02, 11'h002, 3'd0);
      tbl[16] = mkv(14'h00A5, 0, 1, ALU_OP_PASSF,  0, BIT_OP_TEST, PC_OP_INC,  6'b000000, 1, 8'h03, 7'h03, 11'h103, 3'd2);
      tbl[17] = mkv(14'h0009, 0, 0, ALU_OP_PASSW,  0, BIT_OP_NONE, PC_OP_INC,  6'b010000, 1, 8'hA5, 7'h25, 11'h0A5, 3'd1);
      tbl[18] = mkv(14'h1D03, 0, 0, ALU_OP_PASSF,  0, BIT_OP_NONE, PC_OP_POP,  6'b000010, 1, 8'h09, 7'h09, 11'h009, 3'd0);
      tbl[19] = nopv(14'h0420, 1'b0, 1'b1);
      tbl[20] = mkv(14'h0000, 0, 0, ALU_OP_IOR,    0, BIT_OP_NONE, PC_OP_INC,  6'b101000, 1, 8'h20, 7'h20, 11'h420, 3'd0);
      tbl[21] = mkv(14'h0000, 0, 0, ALU_OP_PASSF,  0, BIT_OP_NONE, PC_OP_INC,  6'b000000, 1, 8'h00, 7'h00, 11'h000, 3'd0);
      tbl[22] = mkv(14'h07A0, 0, 0, ALU_OP_PASSF,  0, BIT_OP_NONE, PC_OP_INC,  6'b000000, 1, 8'h00, 7'h00, 11'h000, 3'd0);

      rst_n                = 1'b0;
      bus.instr_in         = 14'h0000;
      bus.alu_z_raw        = 1'b0;
      bus.alu_bit_test_res = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset q_phase", 32'(bus.q_phase), 32'd0);
      chk("reset pc_op", 32'(bus.pc_op), 32'(PC_OP_INC));
      chk("reset strobes", 32'({bus.alu_status_wr_en, bus.f_wr_en, bus.w_wr_en,
                                bus.stack_push, bus.retfie, bus.illegal}), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 23; i++) run_row(tbl[i], i);

      // ADDWF now executing; pull reset in Q2 and expect an immediate return to a quiet Q1.
      @(posedge clk);
      #1;
      chk("pre-reset q_phase", 32'(bus.q_phase), 32'd1);
      chk("pre-reset alu_op", 32'(bus.alu_op), 32'(ALU_OP_ADD));
      rst_n = 1'b0;
      #1;
      chk("midrst q_phase", 32'(bus.q_phase), 32'd0);
      chk("midrst alu_op", 32'(bus.alu_op), 32'(ALU_OP_PASSF));
      chk("midrst pc_op", 32'(bus.pc_op), 32'(PC_OP_INC));
      any_strobe = 1'b0;
      repeat (6) begin
         @(negedge clk);
         any_strobe = any_strobe | bus.alu_status_wr_en | bus.f_wr_en | bus.w_wr_en |
                      bus.stack_push | bus.retfie | bus.illegal;
      end
      chk("midrst no strobes", 32'(any_strobe), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_row(nopv(14'h07A0, 1'b0, 1'b0), 100);
      run_row(mkv(14'h0000, 0, 0, ALU_OP_ADD, 0, BIT_OP_NONE, PC_OP_INC, 6'b110000, 1,
                  8'hA0, 7'h20, 11'h7A0, 3'd7), 101);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pic_decode_seq.md
Name: pic_decode_seq

Overview:
- Instruction decoder and Q-cycle sequencer for the PIC16F core.
- Latches each fetched 14-bit instruction word and divides every instruction cycle into phases Q1–Q4.
- Drives the ALU's opcode, operand-select and status-write-enable inputs, plus the register file, W, bit unit and PC/stack controls.
- Consumes the ALU's zero and bit-test results to resolve skips, and flushes the prefetched instruction for 2-cycle instructions.

Parameters:
- F_ADDR_W, 7, register-file address width (instr[6:0]).
- PC_W, 11, width of the GOTO/CALL literal driven to the PC unit.

Ports:
- clk  in  1  core clock (one Q phase per clock)
- rst_n  in  1  asynchronous active-low reset
- instr_in  in  14  program-memory word for the next instruction, valid at Q4
- alu_z_raw  in  1  ALU result == 0 (combinational, not the STATUS bit)
- alu_bit_test_res  in  1  selected bit of f, from the bit unit/ALU
- q_phase  out  2  0=Q1, 1=Q2, 2=Q3, 3=Q4
- alu_op  out  4  ALU opcode, from the shared alu_ops header
- alu_sel_lit  out  1  1: op_lf = literal; 0: op_lf = f
- literal  out  8  instr[7:0] of the executing instruction
- alu_status_wr_en  out  1  ALU status write enable, Q3 only
- f_addr  out  F_ADDR_W  register-file address
- f_wr_en  out  1  register-file write strobe, Q4 only
- w_wr_en  out  1  W write strobe, Q4 only
- bit_sel  out  3  bit index for BCF/BSF/BTFSx
- bit_op  out  2  0 none, 1 clear, 2 set, 3 test
- pc_op  out  2  0 inc, 1 load pc_lit, 2 pop stack; held Q1–Q4, sampled by the PC unit at Q4
- stack_push  out  1  CALL push strobe, Q4
- pc_lit  out  PC_W  instr[10:0]
- retfie  out  1  GIE-set strobe, Q4
- illegal  out  1  1-clock pulse at Q4 on an undefined opcode

Behaviour:
- Reset (async):
  - q=Q1, IR=14'h0000 (NOP), flush=1, so the first IR is ignored.
  - All strobes 0, pc_op=inc.
- Phase counter: Q1→Q2→Q3→Q4→Q1, free-running.
- Fetch: at the Q4→Q1 edge, IR <= instr_in. Executing IR overlaps the fetch of the next word.
- Flush:
  - When flush=1, the executing IR is decoded as NOP: no strobes, pc_op=inc, alu_status_wr_en=0.
  - flush is set at the Q4 edge by GOTO, CALL, RETURN, RETLW, RETFIE, or a taken skip. Otherwise it is cleared at the Q4 edge.
- Decode (combinational from IR, stable Q1–Q4):
  - *WF byte ops (ADD/AND/IOR/XOR/SUB/COM/DEC/INC/RLF/RRF/SWAP/MOVF):
    - d=instr[7]; f_addr=instr[6:0].
    - Q4 strobe: f_wr_en=d, w_wr_en=~d.
  - MOVWF: alu_op_passw, f_wr_en, no status.
  - CLRF/CLRW: alu_op_clr; destination per instr[7].
  - Literal ops (ADDLW/ANDLW/IORLW/XORLW/SUBLW/MOVLW/RETLW): alu_sel_lit=1, w_wr_en.
  - MOVLW/RETLW use alu_op_passlf with status write suppressed.
- alu_status_wr_en:
  - 1 only during Q3, for ops that affect STATUS.
  - 0 for MOVWF, MOVLW, RETLW, DECFSZ, INCFSZ, SWAPF, bit ops, branches and NOP.
- Skips, evaluated at Q4:
  - DECFSZ/INCFSZ: taken if alu_z_raw=1.
  - BTFSC: taken if alu_bit_test_res=0.
  - BTFSS: taken if alu_bit_test_res=1.
  - Skip-op writeback still occurs.
- Branches:
  - GOTO: pc_op=load.
  - CALL: pc_op=load plus stack_push.
  - RETURN/RETLW: pc_op=pop.
  - RETFIE: pc_op=pop plus retfie.
- Timing:
  - Single-cycle ops take 4 clocks.
  - Branches and taken skips take 8 clocks; the second cycle is a flushed NOP.
- Special cases:
  - Undefined encodings execute as NOP and pulse illegal.
  - CLRWDT and SLEEP execute as NOP.
  - A skip op sitting in a flushed slot never triggers a skip, so back-to-back skips are each resolved only when executed.
- Reset mid-cycle returns to Q1 with flush=1; no partial Q4 strobe.

Decomposition:
- alu_ops header gains alu_op_ior.
- New shared header pic_decode_ops.vh holds the pc_op, bit_op and q_phase encodings, plus the opcode field masks and values.
- One sub-module, pic_op_decoder: pure combinational, IR → control word.
- The top level holds the Q counter, IR, flush and Q-phase strobe gating.

Test Plan:
- Reset, then instr_in=ADDWF 0x20,d=1 (0x07A0) → after the first flushed cycle:
  - alu_op=add, alu_status_wr_en high at Q3 only.
  - f_wr_en at Q4, f_addr=0x20, w_wr_en=0.
- MOVLW 0x55 (0x3055) → alu_sel_lit=1, literal=0x55, w_wr_en at Q4, alu_status_wr_en never 1.
- GOTO 0x123 (0x2923) followed by ADDLW → pc_op=load with pc_lit=0x123; the next cycle is a flushed NOP with zero strobes.
- DECFSZ 0x30,1 (0x0BB0) with alu_z_raw=1 at Q4 → f_wr_en pulses and the next cycle is flushed. Repeat with alu_z_raw=0 → no flush.
- BTFSS 0x03,2 (0x1D03) with alu_bit_test_res=1 → bit_op=test, bit_sel=2, skip taken. CALL 0x010 → stack_push plus load. RETLW 0xAA → pop, w_wr_en, literal=0xAA.
- Undefined 0x0002 → illegal pulse at Q4, no writes. Assert rst_n low during Q2 → q_phase=0 immediately, strobes 0, flush=1.
